// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial add/subtract sequencer.
//
// A single fulladder cell is time-shared over WIDTH cycles. Bits are processed
// LSB first, and the carry is held in a register between cycles. Operands are
// captured on a start valid/ready handshake. The result is returned on a done
// valid/ready handshake.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start_valid/ready     operand handshake; start_ready is high only in IDLE
//   a, b, cin, sub        operands and op, sampled only on start handshake
//                         (sub=1 computes a-b as a+~b+1, cin ignored)
//   done_valid/ready      result handshake
//   sum, cout, ovf        registered result, carry-out of MSB, signed overflow
//   busy                  high while an operation is in RUN or DONE

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // The counter only needs to reach WIDTH-1. Keep it at least 1 bit wide so WIDTH=1 works.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [WIDTH-1:0] a_shift, b_shift, r_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic             last;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  fulladder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Right shifts. The new result bit enters at the MSB, so after WIDTH steps
  // r_sr holds the sum in natural bit order. Indexing by bit keeps this legal for WIDTH=1.
  always_comb begin
    a_shift = a_sr >> 1;
    b_shift = b_sr >> 1;
    r_shift = r_sr >> 1;
    r_shift[WIDTH-1] = fa_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (done_ready)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE:    start_ready = 1'b1;
      RUN:     busy        = 1'b1;
      DONE:    begin
        done_valid = 1'b1;
        busy       = 1'b1;
      end
      default: start_ready = 1'b0;
    endcase
  end

  // Operand capture / serial step / result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            r_sr  <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_shift;
          b_sr  <= b_shift;
          r_sr  <= r_shift;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= r_shift;
            cout_q <= fa_co;
            // On the last step, carry holds the carry into the MSB.
            ovf_q  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  int nchk  = 0;
  int npass = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one clock. Inputs are driven and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model computed from the arithmetic rules, using plain integers.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mci, input logic msub,
                       output logic [W-1:0] s, output logic co, output logic ov);
    longint ua, ub, ur, sa, sb, r;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
    sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
    if (msub) begin
      ur = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      ur = ua + ub + longint'(mci);
      co = (ur >= (longint'(1) << W));
      r  = sa + sb + longint'(mci);
    end
    s  = ur[W-1:0];
    ov = (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    if (!start_ready) chk("wait_idle", 0, 1);
  endtask

  // One operation. hold: done_ready is high before DONE is reached. Otherwise
  // DONE is back-pressured for bp cycles while start_valid is pulsed.
  // scr: drive random junk on the operand inputs during RUN.
  task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ici, input logic isub, input bit hold, input int bp,
                       input bit scr, input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    logic [W-1:0] s_hold;
    wait_idle();
    a = ia; b = ib; cin = ici; sub = isub;
    start_valid = 1'b1;
    done_ready  = hold;
    tick();
    start_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 40) begin
      chk({tag, "_busy_run"}, busy, 1);
      if (scr) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        start_valid = 1'($urandom);
      end
      tick();
      lat++;
    end
    start_valid = 1'b0;
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_done_valid"}, done_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, eco);
    chk({tag, "_ovf"}, ovf, eov);
    chk({tag, "_start_ready_done"}, start_ready, 0);
    if (!hold) begin
      s_hold = sum;
      for (int i = 0; i < bp; i++) begin
        start_valid = ~start_valid;
        a = W'($urandom); b = W'($urandom);
        tick();
        chk({tag, "_bp_done_valid"}, done_valid, 1);
        chk({tag, "_bp_start_ready"}, start_ready, 0);
        chk({tag, "_bp_sum"}, {sum, cout, ovf}, {s_hold, eco, eov});
      end
      start_valid = 1'b0;
      done_ready  = 1'b1;
    end
    tick();
    done_ready = 1'b0;
    chk({tag, "_done_clear"}, done_valid, 0);
    chk({tag, "_start_ready_after"}, start_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rci, rsub, eco, eov;
    bit           saw;

    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; done_ready = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    // Directed cases
    do_op("add_scr", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b1, 8'h96, 1'b0, 1'b1);
    do_op("carry",   8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h01, 1'b1, 1'b0);
    do_op("sub_brw", 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 0, 1'b0, 8'hF0, 1'b0, 1'b0);
    do_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h7F, 1'b1, 1'b1);
    do_op("bp",      8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 5, 1'b0, 8'h46, 1'b0, 1'b0);

    // Reset in the 4th RUN cycle
    wait_idle();
    a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start_valid = 1'b1; done_ready = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_sum", sum, 8'h00);
    chk("mrst_start_ready", start_ready, 1);
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done_valid) saw = 1'b1;
      tick();
    end
    chk("mrst_no_done", saw, 0);
    do_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h03, 1'b0, 1'b0);

    // Random operations checked against the model
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rci = 1'($urandom); rsub = 1'($urandom);
      if (i % 7 == 0) begin ra = 8'h7F; rb = (i % 2 == 0) ? 8'h01 : 8'h80; end
      model(ra, rb, rci, rsub, es, eco, eov);
      do_op("rand", ra, rb, rci, rsub, 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), es, eco, eov);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
